// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte-stream requesters. A
// requester that wins round-robin arbitration keeps the transmitter until
// its packet's last byte has gone out, so packets never interleave. An owner
// that stalls mid-packet for TIMEOUT cycles loses its grant.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_last     per-requester end-of-packet marker for the offered byte
//   req_ready    combinational accept, only ever for the current owner
//   grant        registered one-hot owner, zero when unowned
//   tx_start     one-cycle load strobe to the UART TX core
//   tx_data      registered byte presented to the UART TX core
//   tx_busy      UART TX core busy status
//   timeout_err  one-cycle pulse when a stalled owner is dropped

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      timeout_err
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  // ACK gives up waiting for busy after this many cycles (4 in total).
  localparam logic [1:0]         ACK_LAST  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ACK,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                last_q, last_d;
  logic                sent_q, sent_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [1:0]          ack_q, ack_d;

  // Round-robin pick: first valid requester scanning ptr+1, ptr+2, ...
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W:0]      cand;

  // NOTE: every signal driven in an always_comb gets a default assignment at
  // the top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!pick_vld && req_valid[cand[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Owner's request lane.
  logic [DATA_W-1:0]   own_data;
  logic                own_valid;
  logic                own_last;

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        own_data  = req_data[i*DATA_W +: DATA_W];
        own_valid = req_valid[i];
        own_last  = req_last[i];
      end
    end
  end

  // The timeout is checked before the handshake so a byte arriving in the
  // very cycle the counter saturates is refused.
  logic timeout_hit;
  logic handshake;

  assign timeout_hit = (state_q == LOAD) && (stall_q == STALL_MAX);
  assign handshake   = (state_q == LOAD) && !timeout_hit && own_valid && !tx_busy;

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_vld) state_d = LOAD;
      LOAD: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (handshake) begin
          state_d = START;
        end
      end
      START: state_d = ACK;
      // A transmitter that never reports busy still gets through ACK.
      ACK:   if (tx_busy || (ack_q == ACK_LAST)) state_d = DRAIN;
      DRAIN: if (!tx_busy) state_d = last_q ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready   = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      LOAD: begin
        timeout_err        = timeout_hit;
        req_ready[owner_q] = handshake;
      end
      START:   tx_start = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    sent_d    = sent_q;
    stall_d   = stall_q;
    ack_d     = ack_q;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        sent_d  = 1'b0;
        if (pick_vld) begin
          owner_d = pick_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      LOAD: begin
        if (timeout_hit) begin
          ptr_d   = owner_q;
          grant_d = '0;
        end else if (handshake) begin
          tx_data_d = own_data;
          last_d    = own_last;
          sent_d    = 1'b1;
          stall_d   = '0;
        end else if (sent_q && (stall_q != STALL_MAX)) begin
          // Waiting for the first byte of a packet is not a stall.
          stall_d = stall_q + 16'd1;
        end
      end
      START: ack_d = '0;
      ACK: begin
        if (!tx_busy && (ack_q != ACK_LAST)) begin
          ack_d = ack_q + 2'd1;
        end
      end
      DRAIN: begin
        if (!tx_busy && last_q) begin
          ptr_d   = owner_q;
          grant_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      sent_q    <= 1'b0;
      stall_q   <= '0;
      ack_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      sent_q    <= sent_d;
      stall_q   <= stall_d;
      ack_q     <= ack_d;
    end
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter. Requesters are per-index queues of
// {last, byte}; a small TX model raises busy two cycles after each tx_start
// for a fixed length (or never, in no-busy mode). Each tx_start is matched
// against an ordered list of (owner, byte) transfers built by each test.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 10;
  localparam int BUSY_RISE = 2;
  localparam int BUSY_LEN  = 20;
  localparam int BUDGET    = 800;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [8:0]         rq [NUM_REQ][$];   // {last, byte} per requester
  int                 exp_owner [$];
  logic [DATA_W-1:0]  exp_data  [$];
  int                 start_cyc [$];
  logic [NUM_REQ-1:0] hs_mask    = '0;
  logic [NUM_REQ-1:0] grant_prev = '0;
  int                 grant_fall_cyc = -1;
  int                 busy_fall_cyc  = -1;
  int                 tx_age         = -1;
  bit                 busy_mode      = 1'b1;
  int                 exp_to_cyc     = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic expect_tx(input int owner, input logic [DATA_W-1:0] data);
    exp_owner.push_back(owner);
    exp_data.push_back(data);
  endtask

  // One clock cycle: drive inputs on the falling edge, then compare.
  task automatic cycle();
    logic nb;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    if (tx_age >= 0) tx_age++;
    nb = busy_mode && (tx_age >= BUSY_RISE) && (tx_age < BUSY_RISE + BUSY_LEN);
    if (tx_busy && !nb) busy_fall_cyc = cyc;
    tx_busy = nb;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]                   = 1'b1;
        req_data[i*DATA_W +: DATA_W]   = rq[i][0][7:0];
        req_last[i]                    = rq[i][0][8];
      end else begin
        req_valid[i]                   = 1'b0;
        req_data[i*DATA_W +: DATA_W]   = '0;
        req_last[i]                    = 1'b0;
      end
    end
    #2;
    hs_mask = req_valid & req_ready;
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    check("ready_owner_only", 32'(req_ready & ~grant), 32'd0);
    check("timeout_err", 32'(timeout_err), 32'(cyc == exp_to_cyc));
    if (tx_start) begin
      start_cyc.push_back(cyc);
      tx_age = 0;
      if (exp_owner.size() == 0) begin
        check("tx_start_unexpected", 32'(tx_start), 32'd0);
      end else begin
        check("tx_grant", 32'(grant), 32'(onehot(exp_owner[0])));
        check("tx_data", 32'(tx_data), 32'(exp_data[0]));
        void'(exp_owner.pop_front());
        void'(exp_data.pop_front());
      end
    end
    if (grant_prev != '0 && grant == '0) grant_fall_cyc = cyc;
    grant_prev = grant;
  endtask

  task automatic run_until_idle(input string name);
    int n;
    n = 0;
    while (!(exp_owner.size() == 0 && grant == '0 && queues_empty()) && n < BUDGET) begin
      cycle();
      n++;
    end
    check({name, "_completes"}, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic wait_starts(input string name, input int count);
    int n;
    n = 0;
    while (start_cyc.size() < count && n < BUDGET) begin
      cycle();
      n++;
    end
    check({name, "_start_seen"}, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic flush_model();
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_owner.delete();
    exp_data.delete();
    hs_mask = '0;
    tx_age  = -1;
    tx_busy = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    flush_model();
    cycle();
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    #2 reset = 1'b0;

    // Single packet from requester 0.
    start_cyc.delete();
    rq[0].push_back({1'b0, 8'hA5});
    rq[0].push_back({1'b0, 8'h3C});
    rq[0].push_back({1'b1, 8'h0F});
    expect_tx(0, 8'hA5);
    expect_tx(0, 8'h3C);
    expect_tx(0, 8'h0F);
    run_until_idle("single");
    check("single_starts", 32'(start_cyc.size()), 32'd3);
    check("single_grant_after", 32'(grant), 32'd0);

    // Pointer now at 0: requester 1 must beat requester 0.
    rq[0].push_back({1'b1, 8'h11});
    rq[1].push_back({1'b1, 8'h22});
    expect_tx(1, 8'h22);
    expect_tx(0, 8'h11);
    run_until_idle("ptr0");

    // No interleave: requester 2 shows up after requester 1's first byte.
    start_cyc.delete();
    rq[1].push_back({1'b0, 8'h41});
    rq[1].push_back({1'b0, 8'h42});
    rq[1].push_back({1'b0, 8'h43});
    rq[1].push_back({1'b1, 8'h44});
    for (int b = 0; b < 4; b++) expect_tx(1, 8'(8'h41 + b));
    expect_tx(2, 8'h55);
    wait_starts("nointerleave", 1);
    rq[2].push_back({1'b1, 8'h55});
    run_until_idle("nointerleave");
    check("nointerleave_starts", 32'(start_cyc.size()), 32'd5);

    // Fairness from reset: 0,1,2,3,0,1,2,3.
    pulse_reset();
    start_cyc.delete();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rq[i].push_back({1'b1, 8'((i + 1) * 16 + p)});
        expect_tx(i, 8'((i + 1) * 16 + p));
      end
    end
    run_until_idle("fair");
    check("fair_starts", 32'(start_cyc.size()), 32'd8);

    // Timeout: requester 3 sends one non-last byte, then goes quiet.
    busy_fall_cyc = -1;
    rq[3].push_back({1'b0, 8'h3A});
    expect_tx(3, 8'h3A);
    begin
      int n;
      n = 0;
      while (busy_fall_cyc < 0 && n < BUDGET) begin
        cycle();
        n++;
      end
      check("timeout_busy_fall_seen", 32'(n < BUDGET), 32'd1);
    end
    // LOAD is re-entered the cycle after busy falls; the pulse comes TIMEOUT
    // cycles after that.
    exp_to_cyc = busy_fall_cyc + 1 + TIMEOUT;
    rq[0].push_back({1'b1, 8'h0A});
    rq[2].push_back({1'b1, 8'h2A});
    expect_tx(0, 8'h0A);
    expect_tx(2, 8'h2A);
    repeat (TIMEOUT + 1) cycle();
    check("timeout_grant_before", 32'(grant), 32'(onehot(3)));
    cycle();
    check("timeout_grant_cleared", 32'(grant), 32'd0);
    run_until_idle("timeout");
    exp_to_cyc = -1;

    // Transmitter that never reports busy: 7 cycles per byte.
    busy_mode = 1'b0;
    start_cyc.delete();
    grant_fall_cyc = -1;
    rq[1].push_back({1'b0, 8'h61});
    rq[1].push_back({1'b0, 8'h62});
    rq[1].push_back({1'b1, 8'h63});
    expect_tx(1, 8'h61);
    expect_tx(1, 8'h62);
    expect_tx(1, 8'h63);
    run_until_idle("nobusy");
    check("nobusy_starts", 32'(start_cyc.size()), 32'd3);
    if (start_cyc.size() == 3) begin
      check("nobusy_gap1", 32'(start_cyc[1] - start_cyc[0]), 32'd7);
      check("nobusy_gap2", 32'(start_cyc[2] - start_cyc[1]), 32'd7);
      check("nobusy_release", 32'(grant_fall_cyc - start_cyc[2]), 32'd6);
    end
    busy_mode = 1'b1;

    // Reset during DRAIN of byte 2 of 3.
    start_cyc.delete();
    rq[0].push_back({1'b0, 8'h71});
    rq[0].push_back({1'b0, 8'h72});
    rq[0].push_back({1'b1, 8'h73});
    expect_tx(0, 8'h71);
    expect_tx(0, 8'h72);
    expect_tx(0, 8'h73);
    wait_starts("midrst", 2);
    begin
      int n;
      n = 0;
      while (!tx_busy && n < 20) begin
        cycle();
        n++;
      end
      check("midrst_busy_seen", 32'(tx_busy), 32'd1);
    end
    repeat (3) cycle();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    flush_model();
    rq[0].push_back({1'b1, 8'h81});
    rq[1].push_back({1'b1, 8'h82});
    rq[2].push_back({1'b1, 8'h83});
    expect_tx(0, 8'h81);
    expect_tx(1, 8'h82);
    expect_tx(2, 8'h83);
    repeat (2) cycle();
    @(posedge clk);
    #3 reset = 1'b0;
    run_until_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte-stream requesters. Each requester sends packets, byte by byte, over a valid/ready handshake with a `last` marker. Once a requester is granted, it keeps the transmitter until its packet ends, so packets from different requesters never interleave. The block sits between the requester logic and the UART TX core and drives that core's start/data inputs from its busy status.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `TIMEOUT`, 1023: cycles an owner may stall mid-packet before losing its grant, 1..65535.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte in `req_data` slice i.
- `req_data`  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  byte offered by requester i is the final byte of its packet.
- `req_ready`  out  NUM_REQ  combinational accept; at most one bit high, and only for the owner.
- `grant`  out  NUM_REQ  one-hot current owner, registered; all-zero when unowned.
- `tx_start`  out  1  single-cycle pulse; the transmitter loads `tx_data`.
- `tx_data`  out  DATA_W  registered byte; stable from `tx_start` until the next accept.
- `tx_busy`  in  1  transmitter busy; rises within 4 cycles after `tx_start` and falls at end of frame.
- `timeout_err`  out  1  single-cycle pulse when an owner's grant is revoked by the timeout.

## Operation
- State machine states: IDLE, LOAD, START, ACK, DRAIN.
- Round-robin pointer `ptr` (log2 NUM_REQ bits) resets to NUM_REQ-1, so requester 0 has first priority after reset.
- **IDLE**, `grant`=0:
  - If any `req_valid` is set, the first set index scanning `ptr+1`, `ptr+2`, ... (mod NUM_REQ) becomes owner.
  - `grant` is registered and the state moves to LOAD.
  - `req_valid` seen in IDLE is never accepted in the same cycle.
- **LOAD**:
  - `req_ready[owner]` = `req_valid[owner]` && !`tx_busy`.
  - On handshake: capture the byte into `tx_data`, capture `req_last[owner]` into `last_q`, clear the stall counter, go to START.
  - With no handshake, the stall counter increments. It counts only when at least one byte of the current packet has already been sent.
  - When the stall counter reaches `TIMEOUT`: pulse `timeout_err`, set `ptr`=owner, clear `grant`, go to IDLE. This is evaluated in the same cycle, and the timeout wins over a same-cycle `req_valid`.
- **START**: `tx_start`=1 for exactly this cycle, then go to ACK.
- **ACK**:
  - Wait for `tx_busy`=1, then go to DRAIN.
  - If `tx_busy` has not risen 4 cycles after START, go to DRAIN anyway. This tolerates a transmitter that does not report busy.
- **DRAIN**: wait for `tx_busy`=0. Then:
  - If `last_q`: set `ptr`=owner, clear `grant`, go to IDLE.
  - Otherwise: go to LOAD with the same owner.
- `req_valid`/`req_data` of non-owners are ignored. Requesters must hold valid and data stable until ready (AXI-style); the block does not check this.
- A requester dropping `req_valid` mid-packet does not lose the grant until the timeout expires.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=0, `timeout_err`=0. State is IDLE, `ptr`=NUM_REQ-1, counters are 0.
- Reset asserted mid-packet: the state machine returns to IDLE immediately. Any byte already started on the transmitter is not tracked. After reset release, arbitration restarts from requester 0.
- Latency:
  - `req_valid` in IDLE to `grant` high: 1 cycle.
  - `grant` to the first possible `req_ready`: same cycle as LOAD, 1 cycle after grant.
  - Handshake to `tx_start`: 1 cycle.
- Back-to-back bytes: the next handshake comes no earlier than 1 cycle after `tx_busy` falls.
- Re-arbitration after `last`: the `tx_busy` fall cycle goes to IDLE. The next `grant` follows 1 cycle later, for a 2-cycle idle gap.
- Single requester streaming packets: it is re-granted on every packet, since round-robin skips non-requesting indices.
- Stall counter width is 16 bits. It saturates at `TIMEOUT` and never wraps.

## Test plan
- **Single packet.** Requester 0 sends 3 bytes A5, 3C, 0F (last on 0F) into a model TX whose busy lasts 20 cycles.
  - Required: 3 `tx_start` pulses with `tx_data` A5, 3C, 0F in order.
  - Required: `grant`=0001 throughout, then 0000, with `ptr`=0.
- **Fairness.** All 4 requesters hold 1-byte packets continuously.
  - Required: grant order 0,1,2,3,0,1, each with one `tx_start`.
  - Required: `req_ready` is never high for more than one bit.
- **No interleave.** Requester 1 sends a 4-byte packet; requester 2 asserts valid after byte 1.
  - Required: all 4 bytes of requester 1 are transmitted before `grant`=0100.
- **Timeout.** `TIMEOUT`=10; requester 3 sends 1 non-last byte, then drops valid.
  - Required: `timeout_err` pulses exactly 10 cycles after LOAD is re-entered, and `grant` clears.
  - Required: requester 0 is granted next.
- **No-busy transmitter.** `tx_busy` is tied to 0.
  - Required: each byte takes START + 4 ACK cycles + 1 DRAIN cycle, and the packet still completes.
- **Reset mid-packet.** Assert `reset` during DRAIN of byte 2 of 3.
  - Required: outputs go to their reset values asynchronously.
  - Required: after release, requester 0 wins if several are requesting.
